// File: rtl/soc_clk_rst_gen.sv
// Clock/reset front end: divides the board clock into cpu_clk and vga_clk, then releases
// the VGA reset and, CPU_RST_DELAY cpu_clk rises later, the CPU reset. Adds a glitch-free CPU halt.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// ST_RST      | synchronised reset still asserted, dividers idle
// ST_VGA_REL  | dividers running, waiting for a vga_clk falling toggle
// ST_CPU_WAIT | vga_reset released, counting CPU_RST_DELAY cpu_clk rises
// ST_CPU_REL  | waiting for a cpu_clk falling toggle to release cpu_reset
// ST_RUN      | both domains out of reset; cpu_halt honoured, cpu_cyc counting
module soc_clk_rst_gen #(
    parameter int CPU_DIV         = 2,
    parameter int VGA_DIV         = 4,
    parameter int RST_SYNC_STAGES = 2,
    parameter int CPU_RST_DELAY   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_halt,
    output logic        cpu_clk,
    output logic        vga_clk,
    output logic        cpu_reset,
    output logic        vga_reset,
    output logic        rst_done,
    output logic [31:0] cpu_cyc
);

    if ((CPU_DIV < 2) || ((CPU_DIV % 2) != 0)) begin : g_bad_cpu_div
        $error("soc_clk_rst_gen: CPU_DIV must be even and >= 2");
    end
    if ((VGA_DIV < 2) || ((VGA_DIV % 2) != 0)) begin : g_bad_vga_div
        $error("soc_clk_rst_gen: VGA_DIV must be even and >= 2");
    end
    if (RST_SYNC_STAGES < 2) begin : g_bad_sync
        $error("soc_clk_rst_gen: RST_SYNC_STAGES must be >= 2");
    end
    if (CPU_RST_DELAY < 1) begin : g_bad_dly
        $error("soc_clk_rst_gen: CPU_RST_DELAY must be >= 1");
    end

    localparam int CPU_HALF = CPU_DIV / 2;
    localparam int VGA_HALF = VGA_DIV / 2;
    localparam int CPU_CW   = (CPU_HALF > 1) ? $clog2(CPU_HALF) : 1;
    localparam int VGA_CW   = (VGA_HALF > 1) ? $clog2(VGA_HALF) : 1;
    localparam int DLY_W    = $clog2(CPU_RST_DELAY + 1);

    localparam logic [CPU_CW-1:0] CPU_TERM = CPU_CW'(CPU_HALF - 1);
    localparam logic [VGA_CW-1:0] VGA_TERM = VGA_CW'(VGA_HALF - 1);
    localparam logic [DLY_W-1:0]  DLY_INIT = DLY_W'(CPU_RST_DELAY);
    localparam logic [DLY_W-1:0]  DLY_ONE  = DLY_W'(1);

    typedef enum logic [2:0] {
        ST_RST,
        ST_VGA_REL,
        ST_CPU_WAIT,
        ST_CPU_REL,
        ST_RUN
    } state_t;

    logic [RST_SYNC_STAGES-1:0] sync_q, sync_d;
    logic                       srst_n;

    logic [CPU_CW-1:0] cpu_cnt_q, cpu_cnt_d;
    logic              cpu_clk_q, cpu_clk_d;
    logic              cpu_held_q, cpu_held_d;
    logic [VGA_CW-1:0] vga_cnt_q, vga_cnt_d;
    logic              vga_clk_q, vga_clk_d;

    state_t            state_q, state_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic              vga_reset_q, vga_reset_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              rst_done_q, rst_done_d;
    logic [31:0]       cpu_cyc_q, cpu_cyc_d;

    logic cpu_tog, vga_tog, halt_en;
    logic cpu_rise, cpu_fall, vga_fall;

    assign sync_d = {sync_q[RST_SYNC_STAGES-2:0], 1'b1};
    assign srst_n = sync_q[RST_SYNC_STAGES-1];

    always_comb begin
        vga_cnt_d = vga_cnt_q;
        vga_clk_d = vga_clk_q;
        vga_tog   = 1'b0;
        if (srst_n) begin
            if (vga_cnt_q == VGA_TERM) begin
                vga_tog   = 1'b1;
                vga_clk_d = ~vga_clk_q;
                vga_cnt_d = '0;
            end else begin
                vga_cnt_d = vga_cnt_q + VGA_CW'(1);
            end
        end
    end

    // A halt only ever parks the clock low; a pending high phase always runs to its full length,
    // and the first edge after halt drops only restarts the count so the low phase stays full too.
    always_comb begin
        cpu_cnt_d  = cpu_cnt_q;
        cpu_clk_d  = cpu_clk_q;
        cpu_held_d = cpu_held_q;
        cpu_tog    = 1'b0;
        halt_en    = cpu_halt && (state_q == ST_RUN);
        if (srst_n) begin
            if (cpu_held_q) begin
                if (!halt_en) begin
                    cpu_held_d = 1'b0;
                    cpu_cnt_d  = '0;
                end
            end else if (halt_en && !cpu_clk_q) begin
                cpu_held_d = 1'b1;
                cpu_cnt_d  = '0;
            end else if (cpu_cnt_q == CPU_TERM) begin
                cpu_tog   = 1'b1;
                cpu_clk_d = ~cpu_clk_q;
                cpu_cnt_d = '0;
                if (halt_en) begin
                    cpu_held_d = 1'b1;
                end
            end else begin
                cpu_cnt_d = cpu_cnt_q + CPU_CW'(1);
            end
        end
    end

    assign cpu_rise = cpu_tog && !cpu_clk_q;
    assign cpu_fall = cpu_tog && cpu_clk_q;
    assign vga_fall = vga_tog && vga_clk_q;

    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        vga_reset_d = vga_reset_q;
        cpu_reset_d = cpu_reset_q;
        rst_done_d  = rst_done_q;
        case (state_q)
            ST_RST: begin
                if (srst_n) begin
                    state_d = ST_VGA_REL;
                end
            end
            ST_VGA_REL: begin
                if (vga_fall) begin
                    vga_reset_d = 1'b1;
                    dly_d       = DLY_INIT;
                    state_d     = ST_CPU_WAIT;
                end
            end
            ST_CPU_WAIT: begin
                if (cpu_rise) begin
                    dly_d = dly_q - DLY_ONE;
                    if (dly_q == DLY_ONE) begin
                        state_d = ST_CPU_REL;
                    end
                end
            end
            ST_CPU_REL: begin
                if (cpu_fall) begin
                    cpu_reset_d = 1'b1;
                    rst_done_d  = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    always_comb begin
        cpu_cyc_d = cpu_cyc_q;
        if ((state_q == ST_RUN) && cpu_rise) begin
            cpu_cyc_d = cpu_cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q      <= '0;
            cpu_cnt_q   <= '0;
            cpu_clk_q   <= 1'b0;
            cpu_held_q  <= 1'b0;
            vga_cnt_q   <= '0;
            vga_clk_q   <= 1'b0;
            state_q     <= ST_RST;
            dly_q       <= '0;
            vga_reset_q <= 1'b0;
            cpu_reset_q <= 1'b0;
            rst_done_q  <= 1'b0;
            cpu_cyc_q   <= '0;
        end else begin
            sync_q      <= sync_d;
            cpu_cnt_q   <= cpu_cnt_d;
            cpu_clk_q   <= cpu_clk_d;
            cpu_held_q  <= cpu_held_d;
            vga_cnt_q   <= vga_cnt_d;
            vga_clk_q   <= vga_clk_d;
            state_q     <= state_d;
            dly_q       <= dly_d;
            vga_reset_q <= vga_reset_d;
            cpu_reset_q <= cpu_reset_d;
            rst_done_q  <= rst_done_d;
            cpu_cyc_q   <= cpu_cyc_d;
        end
    end

    assign cpu_clk   = cpu_clk_q;
    assign vga_clk   = vga_clk_q;
    assign cpu_reset = cpu_reset_q;
    assign vga_reset = vga_reset_q;
    assign rst_done  = rst_done_q;
    assign cpu_cyc   = cpu_cyc_q;

endmodule

// File: tb/tb_soc_clk_rst_gen.sv
// Directed bench for soc_clk_rst_gen: expected edge times are queued when stimulus is applied
// and matched against timestamps captured from the DUT outputs.
module tb_soc_clk_rst_gen;

    logic        clk;
    logic        reset;
    logic        cpu_halt;
    logic        cpu_clk;
    logic        vga_clk;
    logic        cpu_reset;
    logic        vga_reset;
    logic        rst_done;
    logic [31:0] cpu_cyc;

    int n_cmp = 0;
    int n_err = 0;

    time cpu_rise_o[$], cpu_fall_o[$], vga_rise_o[$], vga_fall_o[$];
    time vrst_o[$], crst_o[$], done_o[$];
    time cpu_rise_e[$], cpu_fall_e[$], vga_rise_e[$], vga_fall_e[$];
    time vrst_e[$], crst_e[$], done_e[$];

    soc_clk_rst_gen dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_halt  (cpu_halt),
        .cpu_clk   (cpu_clk),
        .vga_clk   (vga_clk),
        .cpu_reset (cpu_reset),
        .vga_reset (vga_reset),
        .rst_done  (rst_done),
        .cpu_cyc   (cpu_cyc)
    );

    // Rising edges at 0, 10, 20, ...
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    always @(posedge cpu_clk)   cpu_rise_o.push_back($time);
    always @(negedge cpu_clk)   cpu_fall_o.push_back($time);
    always @(posedge vga_clk)   vga_rise_o.push_back($time);
    always @(negedge vga_clk)   vga_fall_o.push_back($time);
    always @(posedge vga_reset) vrst_o.push_back($time);
    always @(posedge cpu_reset) crst_o.push_back($time);
    always @(posedge rst_done)  done_o.push_back($time);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_events(input string tag, input time exp_q[$], input time obs_q[$]);
        time e;
        time o;
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            if (obs_q.size() != 0) o = obs_q.pop_front();
            else o = '1;
            chk($sformatf("%s[%0d]", tag, i), 32'(o), 32'(e));
        end
    endtask

    task automatic clear_all();
        cpu_rise_o.delete(); cpu_fall_o.delete(); vga_rise_o.delete(); vga_fall_o.delete();
        vrst_o.delete(); crst_o.delete(); done_o.delete();
        cpu_rise_e.delete(); cpu_fall_e.delete(); vga_rise_e.delete(); vga_fall_e.delete();
        vrst_e.delete(); crst_e.delete(); done_e.delete();
    endtask

    task automatic wait_until(input time t);
        if (t > $time) #(t - $time);
    endtask

    task automatic chk_all_low(input string tag);
        chk({tag, "_cpu_clk"},   32'(cpu_clk),   32'd0);
        chk({tag, "_vga_clk"},   32'(vga_clk),   32'd0);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
        chk({tag, "_vga_reset"}, 32'(vga_reset), 32'd0);
        chk({tag, "_rst_done"},  32'(rst_done),  32'd0);
        chk({tag, "_cpu_cyc"},   cpu_cyc,        32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        cpu_halt = 1'b0;

        wait_until(5);
        chk_all_low("por");

        // Power-on release; halt pulse while still in CPU_WAIT must be ignored.
        wait_until(22);
        clear_all();
        reset = 1'b1;
        for (int t = 50; t <= 210; t += 20) cpu_rise_e.push_back(t);
        for (int t = 60; t <= 200; t += 20) cpu_fall_e.push_back(t);
        for (int t = 60; t <= 180; t += 40) vga_rise_e.push_back(t);
        for (int t = 80; t <= 200; t += 40) vga_fall_e.push_back(t);
        vrst_e.push_back(80);
        crst_e.push_back(160);
        done_e.push_back(160);

        wait_until(45);
        chk("pre_div_cpu_clk", 32'(cpu_clk), 32'd0);
        wait_until(95);
        cpu_halt = 1'b1;
        wait_until(145);
        cpu_halt = 1'b0;
        wait_until(155);
        chk("wait_vga_reset", 32'(vga_reset), 32'd1);
        chk("wait_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("wait_rst_done",  32'(rst_done),  32'd0);

        wait_until(212);
        chk_events("a_cpu_rise", cpu_rise_e, cpu_rise_o);
        chk_events("a_cpu_fall", cpu_fall_e, cpu_fall_o);
        chk_events("a_vga_rise", vga_rise_e, vga_rise_o);
        chk_events("a_vga_fall", vga_fall_e, vga_fall_o);
        chk_events("a_vga_reset", vrst_e, vrst_o);
        chk_events("a_cpu_reset", crst_e, crst_o);
        chk_events("a_rst_done", done_e, done_o);
        chk("a_cpu_cyc", cpu_cyc, 32'd3);
        clear_all();

        // Halt requested during a high phase: finish it, park low, restart after release.
        wait_until(215);
        cpu_halt = 1'b1;
        cpu_fall_e.push_back(220);
        cpu_rise_e.push_back(270);
        vga_rise_e.push_back(220);
        vga_rise_e.push_back(260);
        vga_fall_e.push_back(240);
        wait_until(255);
        chk("halt_cpu_clk", 32'(cpu_clk), 32'd0);
        chk("halt_cpu_cyc", cpu_cyc, 32'd3);
        cpu_halt = 1'b0;
        wait_until(265);
        chk("restart_cpu_clk", 32'(cpu_clk), 32'd0);
        wait_until(272);
        chk_events("b_cpu_rise", cpu_rise_e, cpu_rise_o);
        chk_events("b_cpu_fall", cpu_fall_e, cpu_fall_o);
        chk_events("b_vga_rise", vga_rise_e, vga_rise_o);
        chk_events("b_vga_fall", vga_fall_e, vga_fall_o);
        chk("b_cpu_cyc", cpu_cyc, 32'd4);
        chk("b_cpu_clk", 32'(cpu_clk), 32'd1);

        // Asynchronous reset mid high phase, then a full replay shifted by 260.
        wait_until(275);
        reset = 1'b0;
        wait_until(276);
        chk_all_low("async");
        wait_until(282);
        clear_all();
        reset = 1'b1;
        for (int t = 310; t <= 410; t += 20) cpu_rise_e.push_back(t);
        for (int t = 320; t <= 400; t += 40) vga_rise_e.push_back(t);
        vrst_e.push_back(340);
        crst_e.push_back(420);
        done_e.push_back(420);
        wait_until(305);
        chk("replay_pre_cpu_clk", 32'(cpu_clk), 32'd0);
        chk("replay_pre_vga_clk", 32'(vga_clk), 32'd0);
        wait_until(422);
        chk_events("c_cpu_rise", cpu_rise_e, cpu_rise_o);
        chk_events("c_vga_rise", vga_rise_e, vga_rise_o);
        chk_events("c_vga_reset", vrst_e, vrst_o);
        chk_events("c_cpu_reset", crst_e, crst_o);
        chk_events("c_rst_done", done_e, done_o);
        chk("c_cpu_cyc", cpu_cyc, 32'd0);

        // Counter wrap.
        wait_until(425);
        force dut.cpu_cyc_q = 32'hFFFF_FFFF;
        wait_until(426);
        release dut.cpu_cyc_q;
        wait_until(427);
        chk("wrap_pre", cpu_cyc, 32'hFFFF_FFFF);
        wait_until(432);
        chk("wrap_post", cpu_cyc, 32'h0000_0000);

        // Halt requested during a low phase: the next rise is suppressed.
        wait_until(445);
        clear_all();
        cpu_halt = 1'b1;
        cpu_rise_e.push_back(470);
        vga_fall_e.push_back(460);
        wait_until(452);
        chk("halt_low_cpu_clk", 32'(cpu_clk), 32'd0);
        chk("halt_low_cpu_cyc", cpu_cyc, 32'd0);
        wait_until(455);
        cpu_halt = 1'b0;
        wait_until(462);
        chk("halt_low_restart", 32'(cpu_clk), 32'd0);
        wait_until(472);
        chk_events("e_cpu_rise", cpu_rise_e, cpu_rise_o);
        chk_events("e_vga_fall", vga_fall_e, vga_fall_o);
        chk("e_cpu_cyc", cpu_cyc, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
